program_loader: RTL and testbench
=================================

# program_loader

Boot-time writer for the processor's 10-bit instruction memory. It accepts a byte stream over a valid/ready handshake, assembles instructions from byte pairs, writes them to consecutive instruction-memory addresses from 0, and verifies a trailing XOR checksum. It holds the processor in reset until a load completes cleanly. It sits between the host byte source and the instruction-memory write port; the core's PC-driven read port is unaffected.

## Interface
- ADDR_WIDTH, 8: instruction-memory address width; matches the 8-bit PC.
- INSTR_WIDTH, 10: instruction width; fixed at 10 (the two-byte packing depends on it).
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; transfer when in_valid && in_ready.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_WIDTH  write address.
- imem_wdata  out  INSTR_WIDTH  write data.
- cpu_hold  out  1  1 = keep processor in reset; drives the core's reset.
- done  out  1  last load passed the checksum.
- error  out  1  last load failed (checksum or format).
- word_count  out  ADDR_WIDTH  number of instructions written by the current or last load.

## Operation
- Stream format: LEN, then LO0 HI0 … LO(N-1) HI(N-1), then CSUM.
- LEN: N = LEN, except LEN = 0 means 256.
- Each instruction = {HI[1:0], LO}. HI[7:2] must be 0.
- CSUM must equal the XOR of every byte after LEN (all LO and HI bytes).
- States and transitions:
  - IDLE: start → LEN.
  - LEN: accept the byte, latch N, clear addr and checksum → LO.
  - LO: accept the byte, latch it → HI.
  - HI: accept the byte. If HI[7:2] ≠ 0 → ERR with no write; otherwise → WRITE.
  - WRITE: one cycle with imem_we = 1, addr and wdata valid; addr and word_count increment at the end of the cycle. If this was the Nth write → CSUM, else → LO.
  - CSUM: accept the byte. Match → DONE, mismatch → ERR.
  - DONE / ERR: hold their flags; start → LEN.
- The running XOR updates on each accepted LO or HI byte.
- The address counter is 8 bits. With N = 256 the last write is address 255; the counter wraps to 0 but no further write occurs.
- On start from DONE or ERR: done, error and word_count clear, and cpu_hold reasserts in the same edge that enters LEN.
- start in any other state is ignored. in_valid outside the accepting states is ignored; no byte is consumed.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, done 0, error 0, word_count 0.
- in_ready = 1 exactly in LEN, LO, HI and CSUM. It is a registered state decode and does not depend on in_valid.
- At most one byte is accepted per cycle.
- imem_we is high exactly one cycle per instruction: the cycle after HI is accepted. in_ready is 0 during WRITE.
- Full stream at in_valid = 1 continuously takes 1 + 3N + 1 cycles after the start cycle, until DONE is entered.
- cpu_hold falls, and done rises, on the same edge that enters DONE. In ERR, cpu_hold stays 1.
- All outputs are registered.
- Reset asserted mid-load returns everything to reset values immediately (asynchronously). Partially written memory contents are not cleaned up; cpu_hold = 1 protects the core.
- in_valid may deassert between any bytes. The FSM waits with no timeout.

## Test plan
- Basic load:
  - Stimulus: start; bytes 02, 34, 01, 7F, 03, then CSUM = 34^01^7F^03 = 49.
  - Response: writes 0x134 @0 and 0x37F @1; done = 1, cpu_hold = 0, word_count = 2.
- Bad checksum:
  - Stimulus: same stream with CSUM = 48.
  - Response: both writes occur; error = 1, done = 0, cpu_hold = 1.
- Format error:
  - Stimulus: LEN = 01, LO = 00, HI = 04.
  - Response: no imem_we pulse; ERR; error = 1.
- LEN = 00:
  - Stimulus: 512 bytes with HI = 00, then a correct CSUM.
  - Response: 256 writes at addresses 0..255; word_count = 0 (wrapped); done = 1.
- Backpressure and flow control:
  - in_valid toggled randomly: write sequence unchanged; no byte is accepted while in WRITE.
  - start pulsed mid-load: ignored.
- Reset mid-operation:
  - Stimulus: reset = 0 for 1 cycle during HI.
  - Response: all outputs at reset values; a subsequent start and full stream loads correctly.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time loader: assembles 10-bit instructions from a LEN/LO/HI.../CSUM byte
// stream, writes them to instruction memory from address 0 and holds the core in reset.
module program_loader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   in_valid_i,
    input  logic [7:0]             in_data_i,
    output logic                   in_ready_o,
    output logic                   imem_we_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    output logic [INSTR_WIDTH-1:0] imem_wdata_o,
    output logic                   cpu_hold_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [ADDR_WIDTH-1:0]  word_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_LO, S_HI, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t state_q, state_d;

    logic                   in_ready_q, in_ready_d;
    logic                   imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0]  imem_addr_q, imem_addr_d;
    logic [INSTR_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
    logic                   cpu_hold_q, cpu_hold_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  last_q, last_d;
    logic [7:0]             lo_q, lo_d;
    logic [7:0]             csum_q, csum_d;
    logic                   fire;
    logic                   restart;

    assign fire    = in_valid_i & in_ready_q;
    assign restart = (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) && start_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start_i) state_d = S_LEN;
            S_LEN:   if (fire) state_d = S_LO;
            S_LO:    if (fire) state_d = S_HI;
            S_HI:    if (fire) state_d = (in_data_i[7:2] != 6'd0) ? S_ERR : S_WRITE;
            // last_q holds N-1, so LEN = 0 naturally ends after address 255
            S_WRITE: state_d = (addr_q == last_q) ? S_CSUM : S_LO;
            S_CSUM:  if (fire) state_d = (in_data_i == csum_q) ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_d   = (state_d == S_LEN) || (state_d == S_LO) ||
                       (state_d == S_HI)  || (state_d == S_CSUM);
        imem_we_d    = (state_d == S_WRITE);
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = done_q;
        error_d      = error_q;
        addr_d       = addr_q;
        last_d       = last_q;
        lo_d         = lo_q;
        csum_d       = csum_q;

        if (restart) begin
            addr_d     = '0;
            cpu_hold_d = 1'b1;
            done_d     = 1'b0;
            error_d    = 1'b0;
        end
        if (state_q == S_LEN && fire) begin
            last_d = ADDR_WIDTH'(in_data_i - 8'd1);
            addr_d = '0;
            csum_d = 8'd0;
        end
        if (state_q == S_LO && fire) begin
            lo_d   = in_data_i;
            csum_d = csum_q ^ in_data_i;
        end
        if (state_q == S_HI && fire) begin
            csum_d = csum_q ^ in_data_i;
            if (state_d == S_WRITE) begin
                imem_addr_d  = addr_q;
                imem_wdata_d = {in_data_i[1:0], lo_q};
            end
        end
        if (state_q == S_WRITE) begin
            addr_d = addr_q + 1'b1;
        end
        if (state_q != S_DONE && state_d == S_DONE) begin
            cpu_hold_d = 1'b0;
            done_d     = 1'b1;
        end
        if (state_q != S_ERR && state_d == S_ERR) begin
            cpu_hold_d = 1'b1;
            error_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            addr_q       <= '0;
            last_q       <= '0;
            lo_q         <= 8'd0;
            csum_q       <= 8'd0;
        end else begin
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
            addr_q       <= addr_d;
            last_q       <= last_d;
            lo_q         <= lo_d;
            csum_q       <= csum_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign cpu_hold_o   = cpu_hold_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign word_count_o = addr_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a stream-level model predicts writes and
// load outcome; a negedge monitor pops and compares whatever the DUT presents.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready_o, imem_we_o, cpu_hold_o, done_o, error_o;
    logic [7:0] imem_addr_o, word_count_o;
    logic [9:0] imem_wdata_o;

    program_loader #(.ADDR_WIDTH(8), .INSTR_WIDTH(10)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready_o),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
        .cpu_hold_o(cpu_hold_o), .done_o(done_o), .error_o(error_o),
        .word_count_o(word_count_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] addr; logic [9:0] data; } wr_t;
    typedef struct { bit done; bit err; logic [7:0] wc; } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];
    wr_t  w_tmp;
    res_t r_tmp;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cyc = 0;
    bit   backp = 0;
    bit   in_load = 0;
    logic prev_flag = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: pops expected writes and load outcomes as the DUT presents them
    always @(negedge clk) begin
        if (rst_ni) begin
            if (imem_we_o) begin
                check("ready_low_in_write", {31'd0, in_ready_o}, 32'd0);
                if (wr_q.size() == 0) fail_now("unexpected_write");
                else begin
                    w_tmp = wr_q.pop_front();
                    check("wr_addr", {24'd0, imem_addr_o}, {24'd0, w_tmp.addr});
                    check("wr_data", {22'd0, imem_wdata_o}, {22'd0, w_tmp.data});
                    $display("write addr=%02h data=%03h", imem_addr_o, imem_wdata_o);
                end
            end
            if ((done_o | error_o) && !prev_flag) begin
                done_cyc = cyc;
                if (res_q.size() == 0) fail_now("unexpected_result");
                else begin
                    r_tmp = res_q.pop_front();
                    check("done", {31'd0, done_o}, {31'd0, r_tmp.done});
                    check("error", {31'd0, error_o}, {31'd0, r_tmp.err});
                    check("cpu_hold", {31'd0, cpu_hold_o}, {31'd0, !r_tmp.done});
                    check("word_count", {24'd0, word_count_o}, {24'd0, r_tmp.wc});
                    $display("load end done=%0b error=%0b hold=%0b wc=%0d",
                             done_o, error_o, cpu_hold_o, word_count_o);
                end
            end
        end
        prev_flag = done_o | error_o;
    end

    // Reference: interpret a byte stream by the format rules
    task automatic model(input logic [7:0] s[$]);
        int n;
        logic [7:0] x, lo, hi;
        n = (s[0] == 8'd0) ? 256 : int'(s[0]);
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
            lo = s[1 + 2*i];
            hi = s[2 + 2*i];
            if (hi[7:2] != 6'd0) begin
                res_q.push_back('{1'b0, 1'b1, i[7:0]});
                return;
            end
            wr_q.push_back('{i[7:0], {hi[1:0], lo}});
            x = x ^ lo ^ hi;
        end
        res_q.push_back('{s[1 + 2*n] == x, s[1 + 2*n] != x, n[7:0]});
    endtask

    task automatic gen(input int len, input int mode, output logic [7:0] s[$]);
        int n, bad;
        logic [7:0] x, lo, hi, flip;
        s = {};
        s.push_back(len[7:0]);
        n = (len == 0) ? 256 : len;
        bad = $urandom_range(0, n - 1);
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom_range(0, 3));
            if (mode == 2 && i == bad) begin
                flip = 8'h04 << $urandom_range(0, 5);
                s.push_back(lo);
                s.push_back(hi | flip);
                return;
            end
            s.push_back(lo);
            s.push_back(hi);
            x = x ^ lo ^ hi;
        end
        flip = 8'h01 << $urandom_range(0, 7);
        s.push_back((mode == 1) ? (x ^ flip) : x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        while (1) begin
            @(negedge clk);
            if (backp && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                if (in_ready_o) begin
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                    return;
                end
            end
            guard++;
            if (guard > 200) begin
                $display("FAIL send_byte_timeout: byte %02h never accepted", b);
                $fatal(1, "loader stalled");
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] s[$], input bit pulse);
        model(s);
        do_start();
        in_load = 1;
        fork
            begin
                foreach (s[k]) send_byte(s[k]);
                in_load = 0;
            end
            begin
                while (pulse && in_load) begin
                    repeat ($urandom_range(2, 6)) @(negedge clk);
                    if (in_load) begin
                        start = 1'b1;
                        @(negedge clk);
                        start = 1'b0;
                    end
                end
            end
        join
        for (int k = 0; k < 50 && res_q.size() != 0; k++) @(negedge clk);
        check("result_pending", res_q.size(), 32'd0);
        check("writes_pending", wr_q.size(), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("rst_imem_we", {31'd0, imem_we_o}, 32'd0);
        check("rst_imem_addr", {24'd0, imem_addr_o}, 32'd0);
        check("rst_imem_wdata", {22'd0, imem_wdata_o}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold_o}, 32'd1);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_error", {31'd0, error_o}, 32'd0);
        check("rst_word_count", {24'd0, word_count_o}, 32'd0);
    endtask

    initial begin
        logic [7:0] s[$];
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        @(negedge clk);
        rst_ni = 1'b1;

        s = '{8'h02, 8'h34, 8'h01, 8'h7F, 8'h03, 8'h49};
        run_load(s, 0);
        check("basic_cycles", done_cyc - start_cyc, 32'd8);

        s = '{8'h02, 8'h34, 8'h01, 8'h7F, 8'h03, 8'h48};
        run_load(s, 0);

        s = '{8'h01, 8'h00, 8'h04};
        run_load(s, 0);

        gen(0, 0, s);
        run_load(s, 0);
        check("len0_cycles", done_cyc - start_cyc, 32'd770);

        backp = 1;
        for (int t = 0; t < 10; t++) begin
            gen($urandom_range(1, 20), $urandom_range(0, 2), s);
            run_load(s, 1);
        end

        // Abort a load with reset while waiting in HI
        backp = 0;
        do_start();
        send_byte(8'h03);
        send_byte(8'h34);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_ni = 1'b1;
        gen(5, 0, s);
        run_load(s, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
